ex_stage_mdu: RTL and testbench
===============================

// Module: ex_stage_mdu
// PURPOSE
//  Execute stage with RV32M multiply/divide: forwarding muxes, single-cycle ALU,
//  and a shared iterative mul/div engine. ALU and MD results leave through one
//  registered EX/MEM output. A valid/ready handshake lets the pipeline stall
//  upstream while an MD op iterates. Sits between the ID/EX and EX/MEM registers.
// PARAMETERS
//  WORD_SIZE  32  datapath width; MD engine iterates WORD_SIZE cycles
//  ADDR_SIZE  10  width of pc and branch_target
// PORTS
//  clk            in   1          single clock, rising edge
//  rst_n          in   1          reset, asynchronous, active-low
//  flush          in   1          kill in-flight op and pending output
//  in_valid       in   1          issue slot holds a valid instruction
//  in_ready       out  1          stage accepts an instruction this cycle
//  pc             in   ADDR_SIZE  pc of the issuing instruction
//  data1/data2    in   WORD_SIZE  register-file operands
//  mem_forward1/2 in   WORD_SIZE  forwarded values from MEM
//  wb_forward1/2  in   WORD_SIZE  forwarded values from WB
//  sel_forward1/2 in   2          0=data, 1=mem, 2=wb, 3=data
//  immd           in   WORD_SIZE  sign-extended immediate
//  alu_op         in   4          ALU operation (`ALU_OP_* encodings)
//  alu_src        in   1          1: ALU B = immd, 0: forwarded operand 2
//  md_en          in   1          instruction is an RV32M op (ignores alu_op)
//  md_op          in   3          funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//  branch, jump   in   1          control flow instruction
//  out_valid      out  1          result/zero/write_data/branch_target valid
//  out_ready      in   1          downstream accepts the output
//  result         out  WORD_SIZE  ALU or MD result (also memory address)
//  write_data     out  WORD_SIZE  forwarded operand 2 (store data)
//  zero           out  1          branch condition
//  branch_target  out  ADDR_SIZE  registered target pc
//  busy           out  1          MD engine iterating
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE, every output register 0. After reset:
//  out_valid=0, busy=0, in_ready=1.
//  Accept condition: in_valid && in_ready.
//  in_ready = (state==IDLE) && (!out_valid || out_ready).
//  Operands: A = fwd mux 1; B = alu_src ? immd : fwd mux 2; write_data = fwd mux 2.
//  Operands are captured on accept; later forwarding changes have no effect.
//  State machine:
//   IDLE -> BUSY on an accepted md_en op (counter=0); otherwise stay in IDLE.
//   BUSY -> DONE when counter==WORD_SIZE-1; the counter increments each cycle.
//   DONE -> IDLE once the result is loaded (out_valid set that cycle).
//  Latency: accepted ALU op at cycle N gives out_valid=1 at N+1.
//   Accepted MD op at cycle N gives out_valid=1 at N+WORD_SIZE+2.
//   in_ready=0 from N+1 until the output is consumed.
//  Output hold: while out_valid && !out_ready, all outputs stay stable.
//  Back-to-back ALU ops sustain one per cycle when out_ready=1.
//  Multiply: shift-add, 2*WORD_SIZE-bit product with sign handling per md_op.
//   MUL returns the low word; MULH/MULHSU/MULHU return the high word.
//  Divide: restoring, on magnitudes with sign fix-up.
//   Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
//   Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
//  zero: for ALU_OP_SLT/SLTU, zero = result[0]; otherwise zero = (result==0).
//   For MD ops, zero = (result==0).
//  branch_target = (branch||jump) ? pc + (immd<<2) : pc, truncated mod 2^ADDR_SIZE.
//  flush (synchronous, highest priority): state -> IDLE, out_valid -> 0,
//   and any in_valid in the same cycle is ignored.
//  Reset mid-iteration: abort, IDLE, no output produced.
// TESTING
//  1 ADD, data1=5, immd=7, alu_src=1, out_ready=1 -> next cycle out_valid=1, result=12, zero=0.
//  2 Forwarding: sel_forward1=1, mem_forward1=0x10, SUB B=0x10 -> result=0, zero=1.
//  3 MULH 0x80000000*0x80000000 -> result=0x40000000 after WORD_SIZE+2 cycles;
//    in_ready=0 and busy=1 throughout the iteration.
//  4 DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0;
//    DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7.
//  5 out_ready=0 for 3 cycles after an ALU result -> outputs frozen, in_ready=0;
//    out_ready=1 -> next op accepted the same cycle.
//  6 flush mid-DIV at iteration 10 -> out_valid stays 0, in_ready=1 next cycle;
//    a following ADD completes normally.

Source files
------------

// File: rtl/ex_stage_mdu.sv
// Execute stage with RV32M support: operand forwarding, a single-cycle ALU
// and a shared iterative multiply/divide engine. ALU and MD results share
// one registered EX/MEM output guarded by a valid/ready handshake.
module ex_stage_mdu #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] data1,
    input  logic [WORD_SIZE-1:0] data2,
    input  logic [WORD_SIZE-1:0] mem_forward1,
    input  logic [WORD_SIZE-1:0] mem_forward2,
    input  logic [WORD_SIZE-1:0] wb_forward1,
    input  logic [WORD_SIZE-1:0] wb_forward2,
    input  logic [1:0]           sel_forward1,
    input  logic [1:0]           sel_forward2,
    input  logic [WORD_SIZE-1:0] immd,
    input  logic [3:0]           alu_op,
    input  logic                 alu_src,
    input  logic                 md_en,
    input  logic [2:0]           md_op,
    input  logic                 branch,
    input  logic                 jump,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] result,
    output logic [WORD_SIZE-1:0] write_data,
    output logic                 zero,
    output logic [ADDR_SIZE-1:0] branch_target,
    output logic                 busy
);

    // ALU operation encodings
    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_AND  = 4'd2;
    localparam logic [3:0] ALU_OP_OR   = 4'd3;
    localparam logic [3:0] ALU_OP_XOR  = 4'd4;
    localparam logic [3:0] ALU_OP_SLL  = 4'd5;
    localparam logic [3:0] ALU_OP_SRL  = 4'd6;
    localparam logic [3:0] ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] ALU_OP_SLT  = 4'd8;
    localparam logic [3:0] ALU_OP_SLTU = 4'd9;
    localparam logic [3:0] ALU_OP_PASSB = 4'd10;

    // RV32M funct3 encodings
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    localparam int CNT_W = $clog2(WORD_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_SIZE - 1);
    localparam logic [WORD_SIZE-1:0] ZERO_W = {WORD_SIZE{1'b0}};
    localparam logic [WORD_SIZE-1:0] ONES_W = {WORD_SIZE{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e state_r, state_n_s;
    logic [CNT_W-1:0] cnt_r;

    logic in_ready_s, busy_s, accept_s;
    logic [WORD_SIZE-1:0] a_s, fwd2_s, b_s;
    logic [WORD_SIZE-1:0] alu_res_s;
    logic alu_zero_s;
    logic [ADDR_SIZE-1:0] tgt_s;

    // MD engine state
    logic [2:0]           md_op_r;
    logic [WORD_SIZE-1:0] opnd_r, hi_r, lo_r, a_r;
    logic                 qneg_r, rneg_r, div0_r;

    logic md_sa_s, md_sb_s, a_neg_s, b_neg_s;
    logic [WORD_SIZE-1:0] a_mag_s, b_mag_s;
    logic [WORD_SIZE-1:0] mul_add_s, hi_n_s, lo_n_s;
    logic [WORD_SIZE:0]   mul_sum_s, div_sh_s, div_diff_s;
    logic [2*WORD_SIZE-1:0] prod_s, prod_fix_s;
    logic [WORD_SIZE-1:0] quo_s, rem_s, md_res_s;
    logic md_zero_s;

    // Output registers
    logic                 out_valid_r, zero_r;
    logic [WORD_SIZE-1:0] result_r, write_data_r;
    logic [ADDR_SIZE-1:0] branch_target_r;

    assign accept_s = in_valid && in_ready_s && !flush;

    // Forwarding muxes and ALU B-operand select
    always_comb begin
        a_s    = data1;
        fwd2_s = data2;
        case (sel_forward1)
            2'd1:    a_s = mem_forward1;
            2'd2:    a_s = wb_forward1;
            default: a_s = data1;
        endcase
        case (sel_forward2)
            2'd1:    fwd2_s = mem_forward2;
            2'd2:    fwd2_s = wb_forward2;
            default: fwd2_s = data2;
        endcase
        if (alu_src) begin
            b_s = immd;
        end else begin
            b_s = fwd2_s;
        end
    end

    // Single-cycle ALU and its branch-condition flag
    always_comb begin
        alu_res_s = ZERO_W;
        case (alu_op)
            ALU_OP_ADD:   alu_res_s = a_s + b_s;
            ALU_OP_SUB:   alu_res_s = a_s - b_s;
            ALU_OP_AND:   alu_res_s = a_s & b_s;
            ALU_OP_OR:    alu_res_s = a_s | b_s;
            ALU_OP_XOR:   alu_res_s = a_s ^ b_s;
            ALU_OP_SLL:   alu_res_s = a_s << b_s[CNT_W-1:0];
            ALU_OP_SRL:   alu_res_s = a_s >> b_s[CNT_W-1:0];
            ALU_OP_SRA:   alu_res_s = $unsigned($signed(a_s) >>> b_s[CNT_W-1:0]);
            ALU_OP_SLT:   alu_res_s = {{(WORD_SIZE-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
            ALU_OP_SLTU:  alu_res_s = {{(WORD_SIZE-1){1'b0}}, (a_s < b_s)};
            ALU_OP_PASSB: alu_res_s = b_s;
            default:      alu_res_s = ZERO_W;
        endcase
        if ((alu_op == ALU_OP_SLT) || (alu_op == ALU_OP_SLTU)) begin
            alu_zero_s = alu_res_s[0];
        end else begin
            alu_zero_s = (alu_res_s == ZERO_W);
        end
    end

    // Branch/jump target, wrapping within the pc width
    always_comb begin
        if (branch || jump) begin
            tgt_s = pc + {immd[ADDR_SIZE-3:0], 2'b00};
        end else begin
            tgt_s = pc;
        end
    end

    // MD operand signedness and magnitudes at issue
    always_comb begin
        md_sa_s = (md_op == MD_MULH) || (md_op == MD_MULHSU) ||
                  (md_op == MD_DIV)  || (md_op == MD_REM);
        md_sb_s = (md_op == MD_MULH) || (md_op == MD_DIV) || (md_op == MD_REM);
        a_neg_s = md_sa_s && a_s[WORD_SIZE-1];
        b_neg_s = md_sb_s && b_s[WORD_SIZE-1];
        if (a_neg_s) begin
            a_mag_s = ZERO_W - a_s;
        end else begin
            a_mag_s = a_s;
        end
        if (b_neg_s) begin
            b_mag_s = ZERO_W - b_s;
        end else begin
            b_mag_s = b_s;
        end
    end

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        if (lo_r[0]) begin
            mul_add_s = opnd_r;
        end else begin
            mul_add_s = ZERO_W;
        end
        mul_sum_s  = {1'b0, hi_r} + {1'b0, mul_add_s};
        div_sh_s   = {hi_r, lo_r[WORD_SIZE-1]};
        div_diff_s = div_sh_s - {1'b0, opnd_r};
        if (md_op_r[2]) begin
            if (!div_diff_s[WORD_SIZE]) begin
                hi_n_s = div_diff_s[WORD_SIZE-1:0];
                lo_n_s = {lo_r[WORD_SIZE-2:0], 1'b1};
            end else begin
                hi_n_s = div_sh_s[WORD_SIZE-1:0];
                lo_n_s = {lo_r[WORD_SIZE-2:0], 1'b0};
            end
        end else begin
            hi_n_s = mul_sum_s[WORD_SIZE:1];
            lo_n_s = {mul_sum_s[0], lo_r[WORD_SIZE-1:1]};
        end
    end

    // Sign fix-up and special cases of the finished MD result
    always_comb begin
        prod_s = {hi_r, lo_r};
        if (qneg_r) begin
            prod_fix_s = {(2*WORD_SIZE){1'b0}} - prod_s;
        end else begin
            prod_fix_s = prod_s;
        end
        if (div0_r) begin
            quo_s = ONES_W;
            rem_s = a_r;
        end else begin
            quo_s = qneg_r ? (ZERO_W - lo_r) : lo_r;
            rem_s = rneg_r ? (ZERO_W - hi_r) : hi_r;
        end
        case (md_op_r)
            MD_MUL:                         md_res_s = prod_fix_s[WORD_SIZE-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:   md_res_s = prod_fix_s[2*WORD_SIZE-1:WORD_SIZE];
            MD_DIV, MD_DIVU:                md_res_s = quo_s;
            MD_REM, MD_REMU:                md_res_s = rem_s;
            default:                        md_res_s = ZERO_W;
        endcase
        md_zero_s = (md_res_s == ZERO_W);
    end

    // MD engine registers: load on issue, iterate while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_op_r <= 3'd0;
            opnd_r  <= ZERO_W;
            hi_r    <= ZERO_W;
            lo_r    <= ZERO_W;
            a_r     <= ZERO_W;
            qneg_r  <= 1'b0;
            rneg_r  <= 1'b0;
            div0_r  <= 1'b0;
        end else if (accept_s && md_en) begin
            md_op_r <= md_op;
            a_r     <= a_s;
            qneg_r  <= a_neg_s ^ b_neg_s;
            rneg_r  <= a_neg_s;
            div0_r  <= (b_s == ZERO_W);
            hi_r    <= ZERO_W;
            if (md_op[2]) begin
                opnd_r <= b_mag_s;
                lo_r   <= a_mag_s;
            end else begin
                opnd_r <= a_mag_s;
                lo_r   <= b_mag_s;
            end
        end else if (state_r == ST_BUSY) begin
            hi_r <= hi_n_s;
            lo_r <= lo_n_s;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // FSM next-state logic; flush overrides everything
    always_comb begin
        state_n_s = state_r;
        if (flush) begin
            state_n_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_n_s = (accept_s && md_en) ? ST_BUSY : ST_IDLE;
                ST_BUSY: state_n_s = (cnt_r == CNT_LAST) ? ST_DONE : ST_BUSY;
                ST_DONE: state_n_s = ST_IDLE;
                default: state_n_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: issue readiness and engine activity
    always_comb begin
        in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
        busy_s     = (state_r == ST_BUSY);
    end

    // Iteration counter, cleared whenever the engine is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_BUSY) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // EX/MEM output register with valid/ready hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r     <= 1'b0;
            result_r        <= ZERO_W;
            zero_r          <= 1'b0;
            write_data_r    <= ZERO_W;
            branch_target_r <= {ADDR_SIZE{1'b0}};
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            write_data_r    <= fwd2_s;
            branch_target_r <= tgt_s;
            if (md_en) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= 1'b1;
                result_r    <= alu_res_s;
                zero_r      <= alu_zero_s;
            end
        end else if (state_r == ST_DONE) begin
            out_valid_r <= 1'b1;
            result_r    <= md_res_s;
            zero_r      <= md_zero_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready      = in_ready_s;
    assign busy          = busy_s;
    assign out_valid     = out_valid_r;
    assign result        = result_r;
    assign zero          = zero_r;
    assign write_data    = write_data_r;
    assign branch_target = branch_target_r;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu: reset state, ALU, forwarding, branch
// target, iterative MD ops, output hold, back-to-back issue, flush and reset.
module tb_ex_stage_mdu;

    localparam int W = 32;
    localparam int A = 10;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, in_ready;
    logic [A-1:0] pc;
    logic [W-1:0] data1, data2, mem_forward1, mem_forward2, wb_forward1, wb_forward2;
    logic [1:0]   sel_forward1, sel_forward2;
    logic [W-1:0] immd;
    logic [3:0]   alu_op;
    logic         alu_src, md_en;
    logic [2:0]   md_op;
    logic         branch, jump;
    logic         out_valid, out_ready;
    logic [W-1:0] result, write_data;
    logic         zero;
    logic [A-1:0] branch_target;
    logic         busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_stage_mdu #(.WORD_SIZE(W), .ADDR_SIZE(A)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .pc(pc),
        .data1(data1), .data2(data2),
        .mem_forward1(mem_forward1), .mem_forward2(mem_forward2),
        .wb_forward1(wb_forward1), .wb_forward2(wb_forward2),
        .sel_forward1(sel_forward1), .sel_forward2(sel_forward2),
        .immd(immd), .alu_op(alu_op), .alu_src(alu_src),
        .md_en(md_en), .md_op(md_op), .branch(branch), .jump(jump),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .write_data(write_data), .zero(zero),
        .branch_target(branch_target), .busy(busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pc = 10'd0; data1 = 32'd0; data2 = 32'd0;
        mem_forward1 = 32'd0; mem_forward2 = 32'd0;
        wb_forward1 = 32'd0; wb_forward2 = 32'd0;
        sel_forward1 = 2'd0; sel_forward2 = 2'd0;
        immd = 32'd0; alu_op = OP_ADD; alu_src = 1'b0;
        md_en = 1'b0; md_op = 3'd0; branch = 1'b0; jump = 1'b0;
    endtask

    task automatic test_reset;
        #3 rst_n = 1'b0;
        #4;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
        checks++; if (result !== 32'd0 || branch_target !== 10'd0 || zero !== 1'b0)
            begin errors++; $display("FAIL reset_regs got result=%0h tgt=%0h zero=%0h exp=0", result, branch_target, zero); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add;
        alu_op = OP_ADD; data1 = 32'd5; data2 = 32'h33; immd = 32'd7; alu_src = 1'b1;
        pc = 10'h010; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got=%0h exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'd12 || zero !== 1'b0)
            begin errors++; $display("FAIL add_result got v=%0h r=%0h z=%0h exp v=1 r=c z=0", out_valid, result, zero); end
        checks++; if (write_data !== 32'h33 || branch_target !== 10'h010)
            begin errors++; $display("FAIL add_side got wd=%0h tgt=%0h exp wd=33 tgt=10", write_data, branch_target); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got=%0h exp=0", out_valid); end
    endtask

    task automatic test_forward;
        alu_op = OP_SUB; alu_src = 1'b0;
        sel_forward1 = 2'd1; mem_forward1 = 32'h10; data1 = 32'h99;
        sel_forward2 = 2'd2; wb_forward2 = 32'h10; data2 = 32'h77;
        in_valid = 1'b1;
        step();
        checks++; if (result !== 32'd0 || zero !== 1'b1 || write_data !== 32'h10)
            begin errors++; $display("FAIL fwd_sub got r=%0h z=%0h wd=%0h exp r=0 z=1 wd=10", result, zero, write_data); end
        alu_op = OP_SLT; sel_forward1 = 2'd2; wb_forward1 = 32'hFFFF_FFFF;
        sel_forward2 = 2'd3; data2 = 32'd1;
        step();
        checks++; if (result !== 32'd1 || zero !== 1'b1)
            begin errors++; $display("FAIL fwd_slt got r=%0h z=%0h exp r=1 z=1", result, zero); end
        alu_op = OP_SLTU;
        step();
        in_valid = 1'b0;
        checks++; if (result !== 32'd0 || zero !== 1'b0)
            begin errors++; $display("FAIL fwd_sltu got r=%0h z=%0h exp r=0 z=0", result, zero); end
        sel_forward1 = 2'd0; sel_forward2 = 2'd0;
        step();
    endtask

    task automatic test_branch_target;
        alu_op = OP_ADD; alu_src = 1'b1; data1 = 32'd0;
        branch = 1'b1; pc = 10'h3F0; immd = 32'd8; in_valid = 1'b1;
        step();
        checks++; if (branch_target !== 10'h010)
            begin errors++; $display("FAIL br_target_wrap got=%0h exp=10", branch_target); end
        branch = 1'b0; jump = 1'b1; pc = 10'h005; immd = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0; jump = 1'b0;
        checks++; if (branch_target !== 10'h001 || result !== 32'hFFFF_FFFF)
            begin errors++; $display("FAIL jmp_target got tgt=%0h r=%0h exp tgt=1 r=ffffffff", branch_target, result); end
        step();
    endtask

    task automatic test_mulh;
        int bad;
        bad = 0;
        alu_src = 1'b0; md_en = 1'b1; md_op = 3'd1;
        data1 = 32'h8000_0000; data2 = 32'h8000_0000; in_valid = 1'b1;
        step();
        in_valid = 1'b0; md_en = 1'b0;
        for (int k = 0; k < W; k++) begin
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mulh_busy_window got bad_cycles=%0d exp=0", bad); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL mulh_done_state got busy=%0h rdy=%0h v=%0h exp 0 0 0", busy, in_ready, out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || result !== 32'h4000_0000 || zero !== 1'b0)
            begin errors++; $display("FAIL mulh_result got v=%0h r=%0h z=%0h exp v=1 r=40000000 z=0", out_valid, result, zero); end
        step();
    endtask

    task automatic test_md_vectors;
        logic [2:0]  ops  [11];
        logic [31:0] va   [11];
        logic [31:0] vb   [11];
        logic [31:0] vexp [11];
        int n;
        ops[0]  = 3'd0; va[0]  = 32'd7;          vb[0]  = 32'hFFFF_FFFD; vexp[0]  = 32'hFFFF_FFEB;
        ops[1]  = 3'd3; va[1]  = 32'hFFFF_FFFF;  vb[1]  = 32'hFFFF_FFFF; vexp[1]  = 32'hFFFF_FFFE;
        ops[2]  = 3'd2; va[2]  = 32'hFFFF_FFFF;  vb[2]  = 32'hFFFF_FFFF; vexp[2]  = 32'hFFFF_FFFF;
        ops[3]  = 3'd4; va[3]  = 32'h8000_0000;  vb[3]  = 32'hFFFF_FFFF; vexp[3]  = 32'h8000_0000;
        ops[4]  = 3'd6; va[4]  = 32'h8000_0000;  vb[4]  = 32'hFFFF_FFFF; vexp[4]  = 32'h0000_0000;
        ops[5]  = 3'd5; va[5]  = 32'd7;          vb[5]  = 32'd0;         vexp[5]  = 32'hFFFF_FFFF;
        ops[6]  = 3'd7; va[6]  = 32'd7;          vb[6]  = 32'd0;         vexp[6]  = 32'd7;
        ops[7]  = 3'd4; va[7]  = 32'hFFFF_FFF9;  vb[7]  = 32'd2;         vexp[7]  = 32'hFFFF_FFFD;
        ops[8]  = 3'd6; va[8]  = 32'hFFFF_FFF9;  vb[8]  = 32'd2;         vexp[8]  = 32'hFFFF_FFFF;
        ops[9]  = 3'd4; va[9]  = 32'hFFFF_FFF9;  vb[9]  = 32'd0;         vexp[9]  = 32'hFFFF_FFFF;
        ops[10] = 3'd6; va[10] = 32'hFFFF_FFF9;  vb[10] = 32'd0;         vexp[10] = 32'hFFFF_FFF9;
        alu_src = 1'b0;
        for (int i = 0; i < 11; i++) begin
            md_en = 1'b1; md_op = ops[i]; data1 = va[i]; data2 = vb[i]; in_valid = 1'b1;
            step();
            in_valid = 1'b0; md_en = 1'b0;
            n = 0;
            while (out_valid !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            checks++; if (n != W + 1) begin errors++; $display("FAIL md_latency[%0d] got=%0d exp=%0d", i, n, W + 1); end
            checks++; if (result !== vexp[i] || zero !== (vexp[i] == 32'd0))
                begin errors++; $display("FAIL md_result[%0d] got r=%0h z=%0h exp r=%0h", i, result, zero, vexp[i]); end
        end
        step();
    endtask

    task automatic test_hold;
        int bad;
        bad = 0;
        alu_op = OP_ADD; alu_src = 1'b1; data1 = 32'd1; immd = 32'd2;
        out_ready = 1'b0; in_valid = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || result !== 32'd3)
            begin errors++; $display("FAIL hold_first got v=%0h r=%0h exp v=1 r=3", out_valid, result); end
        data1 = 32'd10; immd = 32'd20;
        for (int k = 0; k < 3; k++) begin
            if (out_valid !== 1'b1 || result !== 32'd3 || in_ready !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_frozen got bad_cycles=%0d exp=0", bad); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got=%0h exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'd30)
            begin errors++; $display("FAIL hold_next got v=%0h r=%0h exp v=1 r=1e", out_valid, result); end
        step();
    endtask

    task automatic test_back_to_back;
        alu_op = OP_ADD; alu_src = 1'b1; immd = 32'd100; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data1 = 32'(i * 3); in_valid = 1'b1;
            step();
            checks++; if (out_valid !== 1'b1 || result !== 32'(100 + i * 3))
                begin errors++; $display("FAIL b2b[%0d] got v=%0h r=%0h exp v=1 r=%0h", i, out_valid, result, 100 + i * 3); end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush;
        int seen;
        seen = 0;
        alu_op = OP_ADD; alu_src = 1'b1; data1 = 32'd9; immd = 32'd1;
        in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_ignored got=%0h exp=0", out_valid); end
        alu_src = 1'b0; md_en = 1'b1; md_op = 3'd4; data1 = 32'd100; data2 = 32'd7; in_valid = 1'b1;
        step();
        md_en = 1'b0; in_valid = 1'b0;
        repeat (10) step();
        flush = 1'b1; alu_src = 1'b1; data1 = 32'd1; immd = 32'd1; in_valid = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL flush_mid_div got v=%0h rdy=%0h busy=%0h exp 0 1 0", out_valid, in_ready, busy); end
        for (int k = 0; k < 40; k++) begin
            if (out_valid !== 1'b0) seen++;
            step();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_output got=%0d exp=0", seen); end
        data1 = 32'd2; immd = 32'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'd5)
            begin errors++; $display("FAIL flush_after_add got v=%0h r=%0h exp v=1 r=5", out_valid, result); end
        step();
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        alu_src = 1'b0; md_en = 1'b1; md_op = 3'd0; data1 = 32'd3; data2 = 32'd4; in_valid = 1'b1;
        step();
        md_en = 1'b0; in_valid = 1'b0;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL reset_mid got busy=%0h v=%0h rdy=%0h exp 0 0 1", busy, out_valid, in_ready); end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (out_valid !== 1'b0) seen++;
            step();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL reset_mid_no_output got=%0d exp=0", seen); end
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_add();
        test_forward();
        test_branch_target();
        test_mulh();
        test_md_vectors();
        test_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
